// File: rtl/evm_pkg.sv
// Shared types and constants for the ballot unit: FSM states, candidate
// one-hot codes and the ballot count ceiling.
package evm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DEBOUNCE,
    ST_CAST,
    ST_BEEP_HOLD,
    ST_RELEASE
  } evm_state_e;

  // Sample vector bit order is {NOTA, P3, P2, P1}
  localparam logic [3:0] CAND_P1   = 4'b0001;
  localparam logic [3:0] CAND_P2   = 4'b0010;
  localparam logic [3:0] CAND_P3   = 4'b0100;
  localparam logic [3:0] CAND_NOTA = 4'b1000;

  localparam logic [6:0] MAX_BALLOTS = 7'd99;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/evm_btn_sample.sv
// Single register stage on the raw voter buttons plus press classification
// (none / exactly one / several) of the registered sample.
module evm_btn_sample
  import evm_pkg::*;
(
  input  logic       clk_i,
  input  logic       clear_i,
  input  logic [3:0] btn_i,
  output logic [3:0] sample_o,
  output logic       zero_o,
  output logic       one_hot_o,
  output logic       multi_o
);

  logic [3:0] sample_q;
  logic [2:0] pop;

  always_ff @(posedge clk_i) begin
    if (clear_i) sample_q <= '0;
    else         sample_q <= btn_i;
  end

  assign pop       = popcount4(sample_q);
  assign sample_o  = sample_q;
  assign zero_o    = (sample_q == 4'b0000);
  assign one_hot_o = (pop == 3'd1);
  assign multi_o   = (pop > 3'd1);

endmodule

// File: rtl/evm_ballot_unit.sv
// Ballot unit FSM: IDLE -> ARMED -> DEBOUNCE -> CAST -> BEEP_HOLD -> RELEASE -> IDLE.
// One vote per arming; debounce counts up to DEBOUNCE_CYCLES, beep timer counts down.
module evm_ballot_unit
  import evm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BEEP_CYCLES     = 8
) (
  input  logic       CLK,
  input  logic       CLEAR,
  input  logic       BALLOT_EN,
  input  logic       P1,
  input  logic       P2,
  input  logic       P3,
  input  logic       NOTA,
  output logic       VOTE_P1,
  output logic       VOTE_P2,
  output logic       VOTE_P3,
  output logic       VOTE_NOTA,
  output logic       READY_LED,
  output logic       BEEP,
  output logic       MULTI_ERR,
  output logic [6:0] BALLOTS_CAST
);

  localparam logic [3:0] DEB_TC  = 4'(DEBOUNCE_CYCLES);
  localparam logic [7:0] BEEP_LD = 8'(BEEP_CYCLES);

  evm_state_e state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] deb_q, deb_d;
  logic [7:0] beep_q, beep_d;
  logic [6:0] ballots_q, ballots_d;

  logic [3:0] s;
  logic       s_zero, s_one_hot, s_multi;

  evm_btn_sample u_sample (
    .clk_i     (CLK),
    .clear_i   (CLEAR),
    .btn_i     ({NOTA, P3, P2, P1}),
    .sample_o  (s),
    .zero_o    (s_zero),
    .one_hot_o (s_one_hot),
    .multi_o   (s_multi)
  );

  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      state_q   <= ST_IDLE;
      cand_q    <= '0;
      deb_q     <= '0;
      beep_q    <= '0;
      ballots_q <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      deb_q     <= deb_d;
      beep_q    <= beep_d;
      ballots_q <= ballots_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    deb_d     = deb_q;
    beep_d    = beep_q;
    ballots_d = ballots_q;
    unique case (state_q)
      ST_IDLE: begin
        // A button already down when the key is turned must not become a vote
        if (BALLOT_EN && s_zero) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (s_one_hot) begin
          state_d = ST_DEBOUNCE;
          cand_d  = s;
          deb_d   = 4'd1;
        end
      end
      ST_DEBOUNCE: begin
        if (s != cand_q) begin
          state_d = ST_ARMED;
          deb_d   = '0;
        end else if (deb_q == DEB_TC) begin
          state_d = ST_CAST;
        end else begin
          deb_d = deb_q + 4'd1;
        end
      end
      ST_CAST: begin
        state_d = ST_BEEP_HOLD;
        deb_d   = '0;
        beep_d  = BEEP_LD;
        if (ballots_q < MAX_BALLOTS) ballots_d = ballots_q + 7'd1;
      end
      ST_BEEP_HOLD: begin
        if (beep_q == 8'd1) begin
          state_d = ST_RELEASE;
          beep_d  = '0;
        end else begin
          beep_d = beep_q - 8'd1;
        end
      end
      ST_RELEASE: begin
        if (s_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign VOTE_P1      = (state_q == ST_CAST) && cand_q[0];
  assign VOTE_P2      = (state_q == ST_CAST) && cand_q[1];
  assign VOTE_P3      = (state_q == ST_CAST) && cand_q[2];
  assign VOTE_NOTA    = (state_q == ST_CAST) && cand_q[3];
  assign READY_LED    = (state_q == ST_ARMED) || (state_q == ST_DEBOUNCE);
  assign BEEP         = (state_q == ST_BEEP_HOLD);
  assign MULTI_ERR    = READY_LED && s_multi;
  assign BALLOTS_CAST = ballots_q;

endmodule
